addr_map_loader: RTL and testbench

- Configuration-side writer for the router address-translation table.
- Accepts an AXI-Stream configuration frame that carries a mode header and one logical address per physical router, and checks that the logical addresses are unique.
- Commits the frame atomically into the flat table vector consumed by the logical-to-physical and physical-to-logical translators.
- Sits between the configuration network port and the translators' table input.

---
 rtl/addr_map_loader.sv | 178 +++++++++++++++++
 tb/tb_addr_map_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_map_loader.sv
// addr_map_loader: loads an AXI-Stream config frame (mode header plus one
// logical address per router), checks that the addresses are unique and
// commits the frame atomically into the flat translation table.
// Ports: clk, rst_n (sync, active low); s_axis_* config stream in;
// table_bits/table_valid active table out; load_busy, commit_done,
// err_valid, err_code status out.
module addr_map_loader #(
  parameter int addr_width  = 4,
  parameter int num_routers = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [addr_width-1:0]             s_axis_tdata,
  input  logic                              s_axis_tlast,
  output logic [addr_width*num_routers:0]   table_bits,
  output logic                              table_valid,
  output logic                              load_busy,
  output logic                              commit_done,
  output logic                              err_valid,
  output logic [1:0]                        err_code
);

  localparam int TW = addr_width * num_routers;
  localparam int NS = 2 ** addr_width;
  localparam int IW = (num_routers > 1) ? $clog2(num_routers) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(num_routers - 1);

  localparam logic [1:0] S_HDR    = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [1:0] E_SHORT = 2'b01;
  localparam logic [1:0] E_LONG  = 2'b10;
  localparam logic [1:0] E_DUP   = 2'b11;

  function automatic logic [TW:0] ident_map();
    logic [TW:0] v;
    v = '0;
    for (int i = 0; i < num_routers; i++) begin
      v[i*addr_width +: addr_width] = addr_width'(i);
    end
    return v;
  endfunction

  localparam logic [TW:0] IDENT = ident_map();

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NS-1:0] seen_q, seen_d;
  logic          dup_q, dup_d;
  logic [TW-1:0] shadow_q, shadow_d;
  logic          smode_q, smode_d;
  logic [TW:0]   table_q, table_d;
  logic          tvalid_q, tvalid_d;
  logic          commit_q, commit_d;
  logic          errv_q, errv_d;
  logic [1:0]    errc_q, errc_d;

  logic accept;
  logic at_last;
  logic dup_hit;

  assign s_axis_tready = (state_q != S_COMMIT);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign at_last       = (idx_q == LAST_IDX);
  // Address already seen earlier in this frame.
  assign dup_hit       = seen_q[s_axis_tdata];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    seen_d   = seen_q;
    dup_d    = dup_q;
    shadow_d = shadow_q;
    smode_d  = smode_q;
    table_d  = table_q;
    tvalid_d = tvalid_q;
    commit_d = 1'b0;
    errv_d   = 1'b0;
    errc_d   = errc_q;
    unique case (state_q)
      S_HDR: begin
        if (accept) begin
          smode_d = s_axis_tdata[0];
          idx_d   = '0;
          seen_d  = '0;
          dup_d   = 1'b0;
          if (s_axis_tlast) begin
            errv_d = 1'b1;
            errc_d = E_SHORT;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          shadow_d[idx_q*addr_width +: addr_width] = s_axis_tdata;
          seen_d[s_axis_tdata] = 1'b1;
          dup_d = dup_q | dup_hit;
          if (s_axis_tlast && !at_last) begin
            errv_d  = 1'b1;
            errc_d  = E_SHORT;
            state_d = S_HDR;
          end else if (at_last && !s_axis_tlast) begin
            errv_d  = 1'b1;
            errc_d  = E_LONG;
            state_d = S_DRAIN;
          end else if (at_last) begin
            // Include a duplicate landing on the closing beat itself.
            if (dup_q || dup_hit) begin
              errv_d  = 1'b1;
              errc_d  = E_DUP;
              state_d = S_HDR;
            end else begin
              state_d = S_COMMIT;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (accept && s_axis_tlast) begin
          state_d = S_HDR;
        end
      end
      S_COMMIT: begin
        table_d  = {smode_q, shadow_q};
        tvalid_d = 1'b1;
        commit_d = 1'b1;
        state_d  = S_HDR;
      end
      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_HDR;
      idx_q    <= '0;
      seen_q   <= '0;
      dup_q    <= 1'b0;
      shadow_q <= '0;
      smode_q  <= 1'b0;
      table_q  <= IDENT;
      tvalid_q <= 1'b0;
      commit_q <= 1'b0;
      errv_q   <= 1'b0;
      errc_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      seen_q   <= seen_d;
      dup_q    <= dup_d;
      shadow_q <= shadow_d;
      smode_q  <= smode_d;
      table_q  <= table_d;
      tvalid_q <= tvalid_d;
      commit_q <= commit_d;
      errv_q   <= errv_d;
      errc_q   <= errc_d;
    end
  end

  assign table_bits  = table_q;
  assign table_valid = tvalid_q;
  assign load_busy   = (state_q != S_HDR);
  assign commit_done = commit_q;
  assign err_valid   = errv_q;
  assign err_code    = errc_q;

endmodule

// File: tb/tb_addr_map_loader.sv
// tb_addr_map_loader: directed and random config frames against a
// frame-level reference model of addr_map_loader.
module tb_addr_map_loader;

  localparam int AW = 4;
  localparam int NR = 4;
  localparam int TW = AW * NR;
  localparam logic [TW:0] IDENT = 17'h03210;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [AW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic [TW:0]   table_bits;
  logic          table_valid;
  logic          load_busy;
  logic          commit_done;
  logic          err_valid;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  addr_map_loader #(
    .addr_width  (AW),
    .num_routers (NR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .table_bits    (table_bits),
    .table_valid   (table_valid),
    .load_busy     (load_busy),
    .commit_done   (commit_done),
    .err_valid     (err_valid),
    .err_code      (err_code)
  );

  int ncmp = 0;
  int nerr = 0;
  int gap_max = 0;

  logic [TW:0]   m_table;
  logic          m_tv;
  logic [1:0]    m_errc;
  logic [AW-1:0] fd[$];
  bit            fl[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [AW-1:0] d, input logic l);
    int g;
    int n;
    g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    s_axis_tvalid = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    n = 0;
    while (!s_axis_tready && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!s_axis_tready) chk("tready_timeout", s_axis_tready, 1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Frame-level outcome: kind 0 commit, 1 short, 2 long, 3 dup;
  // trig = beat after which the outcome is observed.
  function automatic void model(output int kind, output int trig);
    bit used[16];
    kind = -1;
    trig = 0;
    foreach (used[i]) used[i] = 1'b0;
    if (fl[0]) begin
      kind = 1;
      return;
    end
    for (int j = 1; j < fd.size(); j++) begin
      if (j < NR && fl[j]) begin
        kind = 1;
        trig = j;
        return;
      end
      if (j == NR) begin
        trig = j;
        if (!fl[j]) begin
          kind = 2;
          return;
        end
        kind = 0;
        for (int k = 1; k <= NR; k++) begin
          if (used[fd[k]]) kind = 3;
          used[fd[k]] = 1'b1;
        end
        return;
      end
    end
  endfunction

  task automatic run_frame();
    int kind;
    int trig;
    model(kind, trig);
    for (int j = 0; j < fd.size(); j++) begin
      if (kind == 2 && j > trig) chk("drain_tready", s_axis_tready, 1);
      send_beat(fd[j], fl[j]);
      if (j == trig && kind == 0) begin
        chk("commit_early", commit_done, 0);
        chk("commit_tready_low", s_axis_tready, 0);
        @(posedge clk);
        #1;
        m_table[TW] = fd[0][0];
        for (int i = 0; i < NR; i++) m_table[i*AW +: AW] = fd[i+1];
        m_tv = 1'b1;
        chk("commit_done", commit_done, 1);
        chk("commit_tready_back", s_axis_tready, 1);
      end else if (j == trig) begin
        m_errc = (kind == 1) ? 2'b01 : (kind == 2) ? 2'b10 : 2'b11;
        chk("err_valid", err_valid, 1);
        chk("err_code", err_code, m_errc);
        chk("err_no_commit", commit_done, 0);
      end else begin
        chk("no_err_pulse", err_valid, 0);
      end
      if (j < trig) chk("busy", load_busy, 1);
    end
    chk("table", table_bits, m_table);
    chk("table_valid", table_valid, m_tv);
    chk("err_code_hold", err_code, m_errc);
    chk("idle", load_busy, 0);
  endtask

  task automatic set_frame(input logic [AW-1:0] h, input int n,
                           input int lastpos, input logic [31:0] ents);
    fd.delete();
    fl.delete();
    fd.push_back(h);
    fl.push_back(lastpos == 0);
    for (int i = 1; i <= n; i++) begin
      fd.push_back(ents[(i-1)*4 +: 4]);
      fl.push_back(i == lastpos);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_table = IDENT;
    m_tv    = 1'b0;
    m_errc  = 2'b00;
  endtask

  initial begin
    int n;
    logic [31:0] ents;
    bit used[16];
    logic [AW-1:0] v;

    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    rst_n = 1'b1;
    #1;
    do_reset();

    chk("rst_table", table_bits, IDENT);
    chk("rst_table_valid", table_valid, 0);
    chk("rst_tready", s_axis_tready, 1);
    chk("rst_busy", load_busy, 0);
    chk("rst_commit", commit_done, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);

    set_frame(4'h1, 4, 4, 32'h7295);
    run_frame();
    chk("commit_1_table", table_bits, 17'h17295);

    set_frame(4'h0, 4, 4, 32'h7595);
    run_frame();

    set_frame(4'h1, 2, 2, 32'h95);
    run_frame();
    set_frame(4'h0, 4, 4, 32'h2013);
    run_frame();

    set_frame(4'h1, 6, 6, 32'h654321);
    run_frame();

    set_frame(4'h1, 0, 0, 32'h0);
    run_frame();

    send_beat(4'h1, 1'b0);
    send_beat(4'h3, 1'b0);
    send_beat(4'h4, 1'b0);
    chk("pre_reset_busy", load_busy, 1);
    do_reset();
    chk("mid_rst_table", table_bits, IDENT);
    chk("mid_rst_table_valid", table_valid, 0);
    chk("mid_rst_busy", load_busy, 0);
    chk("mid_rst_err_code", err_code, 0);
    set_frame(4'h0, 4, 4, 32'hDCBA);
    run_frame();

    gap_max = 2;
    set_frame(4'h1, 4, 4, 32'h7295);
    run_frame();
    set_frame(4'h0, 4, 4, 32'h7595);
    run_frame();
    set_frame(4'h1, 6, 6, 32'h654321);
    run_frame();

    for (int f = 0; f < 40; f++) begin
      gap_max = $urandom_range(2, 0);
      n = ($urandom_range(2, 0) == 0) ? $urandom_range(6, 0) : NR;
      foreach (used[i]) used[i] = 1'b0;
      ents = '0;
      for (int i = 0; i < n; i++) begin
        v = AW'($urandom_range(15, 0));
        if ($urandom_range(1, 0) == 1) begin
          while (used[v]) v = v + 1'b1;
        end
        used[v] = 1'b1;
        ents[i*4 +: 4] = v;
      end
      set_frame(AW'($urandom_range(15, 0)), n, n, ents);
      run_frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
